hash_sched: RTL and testbench

HASH_SCHED -- requirements
Module: hash_sched

---
 rtl/hash_sched.sv | 160 ++++++++++++++++
 tb/tb_hash_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_sched.sv
`default_nettype none
// ============================================================================
// Module      : hash_sched
// Description : Arbitrates two byte-stream requesters and sequences lookup3
//               init / mix / final commands to a shared hash core.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_sched #(
    parameter logic [31:0] INITVAL = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        s0_valid,
    input  logic [7:0]  s0_data,
    input  logic [7:0]  s0_len,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [7:0]  s1_data,
    input  logic [7:0]  s1_len,
    output logic        s1_ready,
    input  logic        core_ready,
    output logic        init_valid,
    output logic [31:0] init_val,
    output logic        mix_valid,
    output logic [31:0] k0,
    output logic [31:0] k1,
    output logic [31:0] k2,
    output logic        fin_valid,
    output logic [3:0]  fin_w,
    input  logic        core_done,
    input  logic [31:0] core_hash,
    output logic        out_valid,
    output logic [31:0] out_hash,
    output logic        out_id
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_init = 3'd1;
    localparam logic [2:0] c_st_fill = 3'd2;
    localparam logic [2:0] c_st_mix  = 3'd3;
    localparam logic [2:0] c_st_fin  = 3'd4;
    localparam logic [2:0] c_st_wait = 3'd5;
    localparam logic [2:0] c_st_out  = 3'd6;

    localparam logic [31:0] c_golden = 32'hDEADBEEF;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_owner;
    logic        r_prio;
    logic [7:0]  r_len;
    logic [7:0]  r_rem;
    logic [3:0]  r_idx;
    logic [95:0] r_blk;
    logic [31:0] r_hash;

    logic        w_g0;
    logic        w_g1;
    logic        w_own_valid;
    logic [7:0]  w_own_data;
    logic        w_accept;

    // r_prio names the requester that wins the next tie
    assign w_g0        = s0_valid && (!s1_valid || !r_prio);
    assign w_g1        = s1_valid && !w_g0;
    assign w_own_valid = r_owner ? s1_valid : s0_valid;
    assign w_own_data  = r_owner ? s1_data : s0_data;
    assign w_accept    = (r_state == c_st_fill) && w_own_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (s0_valid || s1_valid) w_state_nxt = c_st_init;
            c_st_init: if (core_ready) w_state_nxt = c_st_fill;
            c_st_fill: begin
                // rem of 0 here only happens for an empty key's single beat
                if (w_accept) begin
                    if (r_rem <= 8'd1) begin
                        w_state_nxt = c_st_fin;
                    end else if (r_idx == 4'd11) begin
                        w_state_nxt = c_st_mix;
                    end
                end
            end
            c_st_mix:  if (core_ready) w_state_nxt = c_st_fill;
            c_st_fin:  if (core_ready) w_state_nxt = c_st_wait;
            c_st_wait: if (core_done) w_state_nxt = c_st_out;
            c_st_out:  w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
            r_len   <= 8'd0;
            r_rem   <= 8'd0;
            r_idx   <= 4'd0;
            r_blk   <= 96'd0;
            r_hash  <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_g0 || w_g1) begin
                        r_owner <= w_g1;
                        r_prio  <= w_g0;
                        r_len   <= w_g1 ? s1_len : s0_len;
                        r_rem   <= w_g1 ? s1_len : s0_len;
                        r_idx   <= 4'd0;
                        r_blk   <= 96'd0;
                    end
                end
                c_st_fill: begin
                    if (w_accept && (r_rem != 8'd0)) begin
                        for (int i = 0; i < 12; i++) begin
                            if (r_idx == 4'(i)) r_blk[8*i +: 8] <= w_own_data;
                        end
                        r_rem <= r_rem - 8'd1;
                        r_idx <= r_idx + 4'd1;
                    end
                end
                c_st_mix: begin
                    if (core_ready) begin
                        r_blk <= 96'd0;
                        r_idx <= 4'd0;
                    end
                end
                c_st_wait: begin
                    if (core_done) r_hash <= core_hash;
                end
                default: ;
            endcase
        end
    end

    assign s0_ready   = (r_state == c_st_fill) && !r_owner;
    assign s1_ready   = (r_state == c_st_fill) && r_owner;
    assign init_valid = (r_state == c_st_init) && core_ready;
    assign init_val   = (r_state == c_st_init) ? (c_golden + {24'd0, r_len} + INITVAL) : 32'd0;
    assign mix_valid  = (r_state == c_st_mix) && core_ready;
    assign fin_valid  = (r_state == c_st_fin) && core_ready;
    assign fin_w      = (r_state == c_st_fin) ? r_idx : 4'd0;
    assign k0         = r_blk[31:0];
    assign k1         = r_blk[63:32];
    assign k2         = r_blk[95:64];
    assign out_valid  = (r_state == c_st_out);
    assign out_hash   = r_hash;
    assign out_id     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_hash_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_hash_sched
// Description : Directed self-checking bench for hash_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_sched;

    logic        CLK;
    logic        RST;
    logic        s0_valid, s1_valid;
    logic [7:0]  s0_data, s1_data, s0_len, s1_len;
    logic        s0_ready, s1_ready;
    logic        core_ready;
    logic        init_valid, mix_valid, fin_valid, out_valid;
    logic [31:0] init_val, k0, k1, k2, out_hash, core_hash;
    logic [3:0]  fin_w;
    logic        core_done;
    logic        out_id;

    int checks = 0;
    int errors = 0;

    // observation side, cleared through mon_clr
    logic        mon_clr;
    int          n_init, n_mix, n_fin, n_out, bad_ready, bad_cmd;
    logic [31:0] m_init_val, m_hash;
    logic [95:0] m_mix, m_fin;
    logic [3:0]  m_fin_w;
    logic        m_id;
    logic [5:0]  hist;
    logic        seen0, seen1;

    hash_sched dut (
        .CLK(CLK), .RST(RST),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_len(s0_len), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_len(s1_len), .s1_ready(s1_ready),
        .core_ready(core_ready),
        .init_valid(init_valid), .init_val(init_val),
        .mix_valid(mix_valid), .k0(k0), .k1(k1), .k2(k2),
        .fin_valid(fin_valid), .fin_w(fin_w),
        .core_done(core_done), .core_hash(core_hash),
        .out_valid(out_valid), .out_hash(out_hash), .out_id(out_id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (mon_clr) begin
            n_init <= 0; n_mix <= 0; n_fin <= 0; n_out <= 0;
            bad_ready <= 0; bad_cmd <= 0;
            m_init_val <= 32'd0; m_hash <= 32'd0; m_mix <= 96'd0; m_fin <= 96'd0;
            m_fin_w <= 4'd0; m_id <= 1'b0; hist <= 6'd0; seen0 <= 1'b0; seen1 <= 1'b0;
        end else begin
            if (init_valid) begin
                n_init <= n_init + 1;
                m_init_val <= init_val;
            end
            if (mix_valid) begin
                n_mix <= n_mix + 1;
                if (n_mix == 0) m_mix <= {k2, k1, k0};
            end
            if (fin_valid) begin
                n_fin <= n_fin + 1;
                m_fin <= {k2, k1, k0};
                m_fin_w <= fin_w;
            end
            if (out_valid) begin
                n_out <= n_out + 1;
                m_hash <= out_hash;
                m_id <= out_id;
                hist <= {hist[4:0], out_id};
                if ((out_id && seen0) || (!out_id && seen1)) bad_ready <= bad_ready + 1;
                seen0 <= 1'b0;
                seen1 <= 1'b0;
            end else begin
                if (s0_ready) seen0 <= 1'b1;
                if (s1_ready) seen1 <= 1'b1;
            end
            if (s0_ready && s1_ready) bad_ready <= bad_ready + 1;
            if ((init_valid || mix_valid || fin_valid) && !core_ready) bad_cmd <= bad_cmd + 1;
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        mon_clr = 1'b1;
        @(negedge CLK);
        #1 mon_clr = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 96'({s0_ready, s1_ready}), 96'd0);
        chk({tag, "_valids"}, 96'({init_valid, mix_valid, fin_valid, out_valid}), 96'd0);
        chk({tag, "_init_val"}, 96'(init_val), 96'd0);
        chk({tag, "_k"}, {k2, k1, k0}, 96'd0);
        chk({tag, "_out"}, 96'({out_hash, fin_w, out_id}), 96'd0);
    endtask

    // Drives n0/n1 keys of length l0/l1 with bytes 1,2,3,...; plays the core.
    task automatic run_keys(input int n0, input int n1, input int l0, input int l1,
                            input logic [31:0] hash, input bit stall, input int budget);
        int c0 = 0, c1 = 0, left0 = n0, left1 = n1, cyc = 0, outs = 0, stl = 0;
        bit pend = 0;
        bit in_stall;
        s0_len = 8'(l0);
        s1_len = 8'(l1);
        while (outs < n0 + n1 && cyc < budget) begin
            s0_valid   = (left0 > 0);
            s1_valid   = (left1 > 0);
            s0_data    = 8'(c0 + 1);
            s1_data    = 8'(c1 + 1);
            core_done  = pend;
            core_hash  = pend ? hash : 32'd0;
            pend       = 0;
            in_stall   = stall && (stl < 5) && (c0 == 12);
            core_ready = !in_stall;
            @(negedge CLK);
            if (in_stall) begin
                chk("stall_mix_valid", 96'(mix_valid), 96'd0);
                chk("stall_owner_ready", 96'(s0_ready), 96'd0);
                chk("stall_k_stable", {k2, k1, k0}, 96'h0C0B0A09_08070605_04030201);
                stl++;
            end
            if (s0_valid && s0_ready) begin
                c0++;
                if (c0 == ((l0 == 0) ? 1 : l0)) begin c0 = 0; left0--; end
            end
            if (s1_valid && s1_ready) begin
                c1++;
                if (c1 == ((l1 == 0) ? 1 : l1)) begin c1 = 0; left1--; end
            end
            if (fin_valid) pend = 1;
            if (out_valid) outs++;
            @(posedge CLK);
            #1 cyc++;
        end
        s0_valid   = 1'b0;
        s1_valid   = 1'b0;
        core_done  = 1'b0;
        core_ready = 1'b1;
        chk("key_done_in_budget", 96'(cyc < budget), 96'd1);
    endtask

    initial begin
        int cnt;
        int cyc;
        RST = 1'b1; mon_clr = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0; s0_data = 8'd0; s1_data = 8'd0;
        s0_len = 8'd0; s1_len = 8'd0; core_ready = 1'b1; core_done = 1'b0; core_hash = 32'd0;
        repeat (3) @(posedge CLK);
        #1 chk_reset_outputs("reset");
        RST = 1'b0;
        clr();

        // empty key
        run_keys(1, 0, 0, 0, 32'h12345678, 0, 200);
        chk("len0_init_val", 96'(m_init_val), 96'hDEADBEEF);
        chk("len0_counts", 96'({8'(n_init), 8'(n_mix), 8'(n_fin), 8'(n_out)}), 96'h01000101);
        chk("len0_fin_k", m_fin, 96'd0);
        chk("len0_fin_w", 96'(m_fin_w), 96'd0);
        chk("len0_out", 96'({m_hash, 7'd0, m_id}), 96'({32'h12345678, 8'd0}));
        clr();

        // one full block, finished directly
        run_keys(1, 0, 12, 0, 32'hA5A5A5A5, 0, 200);
        chk("len12_init_val", 96'(m_init_val), 96'hDEADBEFB);
        chk("len12_no_mix", 96'(n_mix), 96'd0);
        chk("len12_fin_k", m_fin, 96'h0C0B0A09_08070605_04030201);
        chk("len12_fin_w", 96'(m_fin_w), 96'd12);
        clr();

        // 13 bytes on requester 1
        run_keys(0, 1, 0, 13, 32'hCAFEF00D, 0, 200);
        chk("len13_init_val", 96'(m_init_val), 96'hDEADBEFC);
        chk("len13_mix_cnt", 96'(n_mix), 96'd1);
        chk("len13_mix_k", m_mix, 96'h0C0B0A09_08070605_04030201);
        chk("len13_fin_k", m_fin, 96'h00000000_00000000_0000000D);
        chk("len13_fin_w", 96'(m_fin_w), 96'd1);
        chk("len13_out", 96'({m_hash, 7'd0, m_id}), 96'({32'hCAFEF00D, 8'd1}));
        clr();

        // 24 bytes: two full blocks, second goes to final
        run_keys(0, 1, 0, 24, 32'h0BADF00D, 0, 300);
        chk("len24_mix_cnt", 96'(n_mix), 96'd1);
        chk("len24_fin_k", m_fin, 96'h18171615_14131211_100F0E0D);
        chk("len24_fin_w", 96'(m_fin_w), 96'd12);
        clr();

        // core back-pressure in MIX
        run_keys(1, 0, 13, 0, 32'h55AA55AA, 1, 300);
        chk("stall_mix_cnt", 96'(n_mix), 96'd1);
        chk("stall_mix_k", m_mix, 96'h0C0B0A09_08070605_04030201);
        chk("stall_fin_k", m_fin, 96'h00000000_00000000_0000000D);
        chk("stall_no_cmd_while_busy", 96'(bad_cmd), 96'd0);

        // contention from reset
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        clr();
        run_keys(3, 3, 2, 2, 32'h13572468, 0, 600);
        chk("rr_order", 96'(hist), 96'b010101);
        chk("rr_nonowner_ready", 96'(bad_ready), 96'd0);
        chk("rr_counts", 96'({8'(n_init), 8'(n_mix), 8'(n_fin), 8'(n_out)}), 96'h06000606);
        chk("rr_no_cmd_while_busy", 96'(bad_cmd), 96'd0);

        // abort a 30-byte key mid-fill
        run_keys(1, 0, 1, 0, 32'h11111111, 0, 200);
        clr();
        s0_len = 8'd30; s0_valid = 1'b1; core_ready = 1'b1;
        cnt = 0; cyc = 0;
        while (cnt < 10 && cyc < 100) begin
            s0_data = 8'(cnt + 1);
            @(negedge CLK);
            if (s0_ready) cnt++;
            @(posedge CLK);
            #1 cyc++;
        end
        chk("abort_fill_reached", 96'(cnt), 96'd10);
        RST = 1'b1;
        @(posedge CLK);
        #1 chk_reset_outputs("abort");
        RST = 1'b0; s0_valid = 1'b0;
        core_done = 1'b1; core_hash = 32'hBAD0BAD0;
        @(posedge CLK);
        #1 core_done = 1'b0;
        repeat (5) @(posedge CLK);
        #1 chk("abort_no_fin_out", 96'({8'(n_fin), 8'(n_out)}), 96'd0);
        clr();
        run_keys(1, 1, 1, 1, 32'h22222222, 0, 300);
        chk("abort_next_grant_s0", 96'({8'(n_out), 6'd0, hist[1:0]}), 96'h0201);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
